// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter feeding one shared single-cycle ALU.
// The result register acts as a one-deep slot drained by the common data bus.
module alu_issue_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*32-1:0]    req_a,
    input  logic [NUM_REQ*32-1:0]    req_b,
    input  logic [NUM_REQ*4-1:0]     req_op,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    input  logic                     flush,
    input  logic                     cdb_ready,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     out_valid,
    output logic [31:0]              out_result,
    output logic [TAG_W-1:0]         out_tag,
    output logic [2:0]               out_src,
    output logic [15:0]              issue_count
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [31:0]      a_arr   [NUM_REQ];
    logic [31:0]      b_arr   [NUM_REQ];
    logic [3:0]       op_arr  [NUM_REQ];
    logic [TAG_W-1:0] tag_arr [NUM_REQ];

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] rr_next;
    logic             found;
    logic             slot_free;
    logic             issue;

    function automatic logic [31:0] alu_eval(input logic [3:0]  op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            default: return 32'd0;
        endcase
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i]   = req_a[32*i +: 32];
        assign b_arr[i]   = req_b[32*i +: 32];
        assign op_arr[i]  = req_op[4*i +: 4];
        assign tag_arr[i] = req_tag[TAG_W*i +: TAG_W];
    end

    // Cyclic search starting at rr_ptr; first requesting position wins.
    always_comb begin
        logic [PTR_W:0] pos;
        found = 1'b0;
        win   = '0;
        pos   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (pos >= (PTR_W+1)'(NUM_REQ)) begin
                pos = pos - (PTR_W+1)'(NUM_REQ);
            end
            if (!found && req[pos[PTR_W-1:0]]) begin
                found = 1'b1;
                win   = pos[PTR_W-1:0];
            end
        end
    end

    assign slot_free = !out_valid || cdb_ready;
    assign issue     = rst_n && slot_free && !flush && found;
    assign rr_next   = (int'(win) == NUM_REQ - 1) ? '0 : win + PTR_W'(1);

    always_comb begin
        grant = '0;
        if (issue) begin
            grant[win] = 1'b1;
        end
    end

    // Result slot: flush kills, issue loads, drain clears, stall holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_tag     <= '0;
            out_src     <= '0;
            issue_count <= '0;
            rr_ptr      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (issue) begin
            out_valid   <= 1'b1;
            out_result  <= alu_eval(op_arr[win], a_arr[win], b_arr[win]);
            out_tag     <= tag_arr[win];
            out_src     <= 3'(win);
            issue_count <= issue_count + 16'd1;
            rr_ptr      <= rr_next;
        end else if (slot_free) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Randomized and directed bench for alu_issue_arbiter with a queue-based
// reference model and an independent output monitor.
module tb_alu_issue_arbiter;

    localparam int N  = 4;
    localparam int TW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N*4-1:0]  req_op;
    logic [N*TW-1:0] req_tag;
    logic            flush;
    logic            cdb_ready;
    logic [N-1:0]    grant;
    logic            out_valid;
    logic [31:0]     out_result;
    logic [TW-1:0]   out_tag;
    logic [2:0]      out_src;
    logic [15:0]     issue_count;

    typedef struct {
        logic [31:0]   res;
        logic [TW-1:0] tag;
        logic [2:0]    src;
    } item_t;

    item_t       exp_q[$];
    int          rr = 0;
    logic [15:0] cnt = '0;
    int          checks = 0;
    int          errors = 0;

    alu_issue_arbiter #(.NUM_REQ(N), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
        .req_op(req_op), .req_tag(req_tag), .flush(flush), .cdb_ready(cdb_ready),
        .grant(grant), .out_valid(out_valid), .out_result(out_result),
        .out_tag(out_tag), .out_src(out_src), .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        if (op == 4'd0) return a + b;
        if (op == 4'd1) return a - b;
        if (op == 4'd2) return a & b;
        if (op == 4'd3) return a | b;
        return 32'd0;
    endfunction

    task automatic set_lane(input int i, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input logic [TW-1:0] tag);
        req_a[32*i +: 32]  = a;
        req_b[32*i +: 32]  = b;
        req_op[4*i +: 4]   = op;
        req_tag[TW*i +: TW] = tag;
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < N; i++) begin
            logic [3:0] op;
            op = ($urandom % 4 == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            set_lane(i, $urandom, $urandom, op, TW'($urandom));
        end
    endtask

    // Reference: one pending-result queue; a grant goes to the first requester
    // at or after rr (cyclically) whenever the slot is free and no flush.
    task automatic model();
        logic [N-1:0] eg;
        int           w;
        item_t        it;
        if (!rst_n) begin
            chk("grant_in_reset", 32'(grant), 32'd0);
            exp_q.delete();
            rr  = 0;
            cnt = '0;
            return;
        end
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("issue_count", 32'(issue_count), 32'(cnt));
        eg = '0;
        w  = -1;
        if ((exp_q.size() == 0 || cdb_ready) && !flush) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (rr + k) % N;
                if (w < 0 && req[idx]) w = idx;
            end
        end
        if (w >= 0) eg[w] = 1'b1;
        chk("grant", 32'(grant), 32'(eg));
        if (flush) begin
            exp_q.delete();
        end else if (w >= 0) begin
            it.res = ref_alu(req_op[4*w +: 4], req_a[32*w +: 32], req_b[32*w +: 32]);
            it.tag = req_tag[TW*w +: TW];
            it.src = 3'(w);
            exp_q.push_back(it);
            rr  = (w + 1) % N;
            cnt = cnt + 16'd1;
        end
    endtask

    task automatic step();
        #1 model();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_out_src", 32'(out_src), 32'd0);
        chk("rst_issue_count", 32'(issue_count), 32'd0);
    endtask

    // Monitor: whatever the DUT presents must match the oldest pending result.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && !flush && out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %h with no result pending", out_result);
                end else begin
                    chk("out_result", out_result, exp_q[0].res);
                    chk("out_tag", 32'(out_tag), 32'(exp_q[0].tag));
                    chk("out_src", 32'(out_src), 32'(exp_q[0].src));
                    if (cdb_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; req = '0; req_a = '0; req_b = '0; req_op = '0; req_tag = '0;
        flush = 1'b0; cdb_ready = 1'b1;
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        check_reset_outputs();

        // single issue: 5 - 3 with tag 7 from requester 0
        set_lane(0, 32'd5, 32'd3, 4'd1, 4'd7);
        req = 4'b0001; step();
        req = 4'b0000; step();

        // round robin over all four requesters
        rand_lanes();
        req = 4'b1111; repeat (5) step();
        req = 4'b0000; step();

        // backpressure stall then release
        rand_lanes();
        req = 4'b0010; cdb_ready = 1'b1; step();
        cdb_ready = 1'b0; repeat (3) step();
        cdb_ready = 1'b1; step();
        req = 4'b0000; step();

        // flush while stalled
        rand_lanes();
        req = 4'b0001; step();
        cdb_ready = 1'b0; flush = 1'b1; req = 4'b0100; step();
        flush = 1'b0; req = 4'b0000; step();
        cdb_ready = 1'b1; step();

        // arithmetic edges
        set_lane(0, 32'hFFFF_FFFF, 32'd1, 4'd0, 4'd1);
        req = 4'b0001; step();
        set_lane(1, 32'd0, 32'd1, 4'd1, 4'd2);
        req = 4'b0010; step();
        set_lane(2, 32'h1234_5678, 32'h0F0F_0F0F, 4'd9, 4'd3);
        req = 4'b0100; step();
        req = 4'b0000; step();

        // randomized traffic with occasional flush and reset
        repeat (3000) begin
            rand_lanes();
            req       = N'($urandom);
            cdb_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 20) == 0;
            rst_n     = ($urandom % 200) != 0;
            step();
        end
        rst_n = 1'b1; flush = 1'b0; cdb_ready = 1'b1; req = '0;

        // issue_count wrap, then reset during a stall
        rst_n = 1'b0; step();
        rst_n = 1'b1;
        rand_lanes();
        req = 4'b1111;
        repeat (65535) step();
        step();
        req = 4'b0001; cdb_ready = 1'b0; step();
        rst_n = 1'b0; req = 4'b1111; step();
        rst_n = 1'b1; cdb_ready = 1'b1;
        check_reset_outputs();
        step();
        req = 4'b0000; step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
